// File: rtl/hsid_mse_comp.sv
// Best/worst match tracker: absorbs one MSE per library reference and keeps
// the running minimum and maximum MSE with their reference indices.
module hsid_mse_comp #(
  parameter int MSE_WIDTH         = 32,
  parameter int HSP_LIBRARY_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         mse_in_valid,
  input  logic [MSE_WIDTH-1:0]         mse_in_value,
  input  logic [HSP_LIBRARY_WIDTH-1:0] mse_in_ref,
  input  logic                         mse_in_last,
  output logic                         mse_in_ready,
  output logic [MSE_WIDTH-1:0]         mse_min_value,
  output logic [HSP_LIBRARY_WIDTH-1:0] mse_min_ref,
  output logic [MSE_WIDTH-1:0]         mse_max_value,
  output logic [HSP_LIBRARY_WIDTH-1:0] mse_max_ref,
  output logic                         mse_comparison_valid,
  output logic                         ref_order_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                         state_r;
  state_t                         state_s;
  logic                           accept_s;
  logic [HSP_LIBRARY_WIDTH-1:0]   sample_count_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else if (clear) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_s      = state_r;
    mse_in_ready = 1'b0;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        mse_in_ready = 1'b1;
        accept_s     = mse_in_valid;
        if (mse_in_valid) begin
          state_s = mse_in_last ? HOLD : TRACK;
        end else begin
          state_s = IDLE;
        end
      end
      TRACK: begin
        mse_in_ready = 1'b1;
        accept_s     = mse_in_valid;
        if (mse_in_valid && mse_in_last) begin
          state_s = HOLD;
        end else begin
          state_s = TRACK;
        end
      end
      HOLD: begin
        mse_in_ready = 1'b0;
        accept_s     = 1'b0;
        state_s      = HOLD;
      end
      default: begin
        mse_in_ready = 1'b0;
        accept_s     = 1'b0;
        state_s      = IDLE;
      end
    endcase
  end

  // Result datapath; strict compares keep the first-seen index on ties.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      mse_min_value        <= {MSE_WIDTH{1'b0}};
      mse_min_ref          <= {HSP_LIBRARY_WIDTH{1'b0}};
      mse_max_value        <= {MSE_WIDTH{1'b0}};
      mse_max_ref          <= {HSP_LIBRARY_WIDTH{1'b0}};
      mse_comparison_valid <= 1'b0;
      ref_order_error      <= 1'b0;
      sample_count_r       <= {HSP_LIBRARY_WIDTH{1'b0}};
    end else if (accept_s) begin
      // The count wraps naturally, so the order check follows the wrap.
      sample_count_r       <= sample_count_r + {{(HSP_LIBRARY_WIDTH-1){1'b0}}, 1'b1};
      mse_comparison_valid <= mse_in_last;
      if (mse_in_ref != sample_count_r) begin
        ref_order_error <= 1'b1;
      end else begin
        ref_order_error <= ref_order_error;
      end
      if (state_r == IDLE) begin
        mse_min_value <= mse_in_value;
        mse_min_ref   <= mse_in_ref;
        mse_max_value <= mse_in_value;
        mse_max_ref   <= mse_in_ref;
      end else begin
        if (mse_in_value < mse_min_value) begin
          mse_min_value <= mse_in_value;
          mse_min_ref   <= mse_in_ref;
        end else begin
          mse_min_value <= mse_min_value;
          mse_min_ref   <= mse_min_ref;
        end
        if (mse_in_value > mse_max_value) begin
          mse_max_value <= mse_in_value;
          mse_max_ref   <= mse_in_ref;
        end else begin
          mse_max_value <= mse_max_value;
          mse_max_ref   <= mse_max_ref;
        end
      end
    end else begin
      mse_comparison_valid <= (state_r == HOLD);
    end
  end

endmodule

// File: tb/tb_hsid_mse_comp.sv
// Self-checking bench for hsid_mse_comp: directed vector table, hand-written
// corner sequences and randomized traffic against a list-based reference model.
module tb_hsid_mse_comp;
  localparam int MW = 16;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n, clear, mse_in_valid, mse_in_last, mse_in_ready;
  logic [MW-1:0] mse_in_value, mse_min_value, mse_max_value;
  logic [LW-1:0] mse_in_ref, mse_min_ref, mse_max_ref;
  logic          mse_comparison_valid, ref_order_error;

  int checks = 0;
  int failures = 0;

  hsid_mse_comp #(.MSE_WIDTH(MW), .HSP_LIBRARY_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .mse_in_valid(mse_in_valid), .mse_in_value(mse_in_value),
    .mse_in_ref(mse_in_ref), .mse_in_last(mse_in_last),
    .mse_in_ready(mse_in_ready),
    .mse_min_value(mse_min_value), .mse_min_ref(mse_min_ref),
    .mse_max_value(mse_max_value), .mse_max_ref(mse_max_ref),
    .mse_comparison_valid(mse_comparison_valid),
    .ref_order_error(ref_order_error)
  );

  always #5 clk = ~clk;

  // Reference model: the list of samples accepted since the last clear/reset.
  logic [MW-1:0] m_vals[$];
  logic [LW-1:0] m_refs[$];
  bit            m_hold = 1'b0;
  bit            m_err  = 1'b0;

  typedef struct {
    logic          r, c, v;
    logic [MW-1:0] val;
    logic [LW-1:0] rf;
    logic          l;
    logic [MW-1:0] e_min;
    logic [LW-1:0] e_minr;
    logic [MW-1:0] e_max;
    logic [LW-1:0] e_maxr;
    logic          e_cv, e_err, e_rdy;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [MW-1:0] mn, mx;
    logic [LW-1:0] mnr, mxr;
    mn = '0; mx = '0; mnr = '0; mxr = '0;
    for (int i = 0; i < m_vals.size(); i++) begin
      if (i == 0 || m_vals[i] < mn) begin mn = m_vals[i]; mnr = m_refs[i]; end
      if (i == 0 || m_vals[i] > mx) begin mx = m_vals[i]; mxr = m_refs[i]; end
    end
    chk("model_min",   32'(mse_min_value), 32'(mn));
    chk("model_min_r", 32'(mse_min_ref),   32'(mnr));
    chk("model_max",   32'(mse_max_value), 32'(mx));
    chk("model_max_r", 32'(mse_max_ref),   32'(mxr));
    chk("model_cv",    32'(mse_comparison_valid), 32'(m_hold));
    chk("model_err",   32'(ref_order_error), 32'(m_err));
    chk("model_rdy",   32'(mse_in_ready), 32'(!m_hold));
  endtask

  // One clock: drive at negedge, update the model at posedge, check 1 after.
  task automatic cyc(input logic r, input logic c, input logic v,
                     input logic [MW-1:0] val, input logic [LW-1:0] rf, input logic l);
    @(negedge clk);
    rst_n = r; clear = c; mse_in_valid = v; mse_in_value = val;
    mse_in_ref = rf; mse_in_last = l;
    @(posedge clk);
    if (!r || c) begin
      m_vals.delete(); m_refs.delete(); m_hold = 1'b0; m_err = 1'b0;
    end else if (v && !m_hold) begin
      if (rf != LW'(m_vals.size())) m_err = 1'b1;
      m_vals.push_back(val); m_refs.push_back(rf);
      if (l) m_hold = 1'b1;
    end
    #1;
    check_model();
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; mse_in_valid = 1'b0;
    mse_in_value = '0; mse_in_ref = '0; mse_in_last = 1'b0;

    //          r     c     v     val       rf     l     min       minr   max       maxr   cv    err   rdy
    tbl[0] = '{1'b0, 1'b0, 1'b0, 16'd0,  4'd0, 1'b0, 16'd0,  4'd0, 16'd0,  4'd0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 16'd50, 4'd0, 1'b0, 16'd50, 4'd0, 16'd50, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 16'd20, 4'd1, 1'b0, 16'd20, 4'd1, 16'd50, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 16'd80, 4'd2, 1'b0, 16'd20, 4'd1, 16'd80, 4'd2, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 16'd20, 4'd3, 1'b1, 16'd20, 4'd1, 16'd80, 4'd2, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 16'd1,  4'd0, 1'b0, 16'd20, 4'd1, 16'd80, 4'd2, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 16'd0,  4'd0, 1'b0, 16'd0,  4'd0, 16'd0,  4'd0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 16'd7,  4'd0, 1'b1, 16'd7,  4'd0, 16'd7,  4'd0, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 16'd1,  4'd0, 1'b0, 16'd7,  4'd0, 16'd7,  4'd0, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 16'd0,  4'd0, 1'b0, 16'd0,  4'd0, 16'd0,  4'd0, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].val, tbl[i].rf, tbl[i].l);
      chk($sformatf("tbl%0d_min", i),   32'(mse_min_value), 32'(tbl[i].e_min));
      chk($sformatf("tbl%0d_min_r", i), 32'(mse_min_ref),   32'(tbl[i].e_minr));
      chk($sformatf("tbl%0d_max", i),   32'(mse_max_value), 32'(tbl[i].e_max));
      chk($sformatf("tbl%0d_max_r", i), 32'(mse_max_ref),   32'(tbl[i].e_maxr));
      chk($sformatf("tbl%0d_cv", i),    32'(mse_comparison_valid), 32'(tbl[i].e_cv));
      chk($sformatf("tbl%0d_err", i),   32'(ref_order_error), 32'(tbl[i].e_err));
      chk($sformatf("tbl%0d_rdy", i),   32'(mse_in_ready), 32'(tbl[i].e_rdy));
    end

    // Skipped reference index sets a sticky order error.
    cyc(1'b1, 1'b0, 1'b1, 16'd5, 4'd0, 1'b0);
    chk("order_before", 32'(ref_order_error), 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 16'd6, 4'd2, 1'b0);
    chk("order_set", 32'(ref_order_error), 32'd1);
    cyc(1'b1, 1'b0, 1'b1, 16'd7, 4'd3, 1'b1);
    chk("order_sticky", 32'(ref_order_error), 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 16'd0, 4'd0, 1'b0);
    chk("order_clear", 32'(ref_order_error), 32'd0);

    // Clear beats a simultaneous accept; then reset mid-stream.
    cyc(1'b1, 1'b0, 1'b1, 16'd10, 4'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 16'd9,  4'd1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 16'd2,  4'd2, 1'b0);
    chk("clr_drop_min", 32'(mse_min_value), 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 16'd3, 4'd0, 1'b0);
    chk("clr_idle_min", 32'(mse_min_value), 32'd3);
    chk("clr_idle_err", 32'(ref_order_error), 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 16'd4, 4'd1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 16'd1, 4'd2, 1'b0);
    chk("rst_mid_max", 32'(mse_max_value), 32'd0);

    // Width extremes, back-to-back.
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 1'b0, 1'b1, (i % 2 == 0) ? 16'hFFFF : 16'h0000, LW'(i), (i == 5) ? 1'b1 : 1'b0);
    chk("ext_min",   32'(mse_min_value), 32'd0);
    chk("ext_min_r", 32'(mse_min_ref),   32'd1);
    chk("ext_max",   32'(mse_max_value), 32'hFFFF);
    chk("ext_max_r", 32'(mse_max_ref),   32'd0);
    chk("ext_cv",    32'(mse_comparison_valid), 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 16'd0, 4'd0, 1'b0);

    // Index wrap: 20 in-order samples, count wraps after 15.
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 1'b0, 1'b1, 16'($urandom_range(0, 999)), LW'(i), (i == 19) ? 1'b1 : 1'b0);
    chk("wrap_err", 32'(ref_order_error), 32'd0);
    chk("wrap_cv",  32'(mse_comparison_valid), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic          r, c, v, l;
      logic [MW-1:0] val;
      logic [LW-1:0] rf;
      r   = ($urandom_range(0, 59) != 0);
      c   = ($urandom_range(0, 24) == 0);
      v   = ($urandom_range(0, 3) != 0);
      l   = ($urandom_range(0, 11) == 0);
      val = ($urandom_range(0, 1) == 0) ? MW'($urandom_range(0, 7)) : MW'($urandom);
      rf  = ($urandom_range(0, 15) == 0) ? LW'($urandom) : LW'(m_vals.size());
      cyc(r, c, v, val, rf, l);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
